// File: rtl/enum_type.sv
// enum_type: shared control event codes used by the input decoders and event_queue
package enum_type;
    typedef enum logic [2:0] {
        NOEVENT = 3'd0,
        LEFT    = 3'd1,
        RIGHT   = 3'd2,
        HOLD    = 3'd3,
        ROTATE  = 3'd4,
        DROP    = 3'd5
    } control_type;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: grants the first requester at index >= ptr, wrapping modulo N
// Ports: req (request per source), ptr (search start), grant_valid, grant_idx
module rr_arbiter #(
    parameter int N = 5
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic                 grant_valid,
    output logic [$clog2(N)-1:0] grant_idx
);
    localparam int PW = $clog2(N);
    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [PW:0]    sum;
    // Rotate so bit 0 is the source at ptr; scan downward so the lowest offset wins.
    always_comb begin
        dbl = {req, req} >> ptr;
        rot = dbl[N-1:0];
        grant_valid = 1'b0;
        grant_idx = '0;
        sum = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                sum = {1'b0, ptr} + (PW+1)'(k);
                grant_valid = 1'b1;
                grant_idx = sum >= (PW+1)'(N) ? PW'(sum - (PW+1)'(N)) : PW'(sum);
            end
        end
    end
endmodule

// File: rtl/event_queue.sv
// event_queue: merges per-source event strobes through pending latches and a round-robin arbiter into a FIFO
// Ports: src_valid/src_event (per-source strobe and code), out_event/out_valid/out_ready (FIFO head handshake),
//        count (occupancy 0..DEPTH), drop_cnt (saturating count of overwritten pending events)
module event_queue
    import enum_type::*;
#(
    parameter int DEPTH   = 16,
    parameter int NUM_SRC = 5
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NUM_SRC-1:0]         src_valid,
    input  control_type                src_event [NUM_SRC],
    output control_type                out_event,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     count,
    output logic [7:0]                 drop_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int PW = $clog2(NUM_SRC);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    control_type          mem [DEPTH];
    control_type          pend_ev [NUM_SRC];
    logic [NUM_SRC-1:0]   pending, load, gnt, drop;
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [PW-1:0]        rr_ptr, grant_idx;
    logic                 grant_valid, pop, can_push;
    logic [8:0]           drop_sum;

    assign out_valid = count != '0;
    assign out_event = out_valid ? mem[rd_ptr] : NOEVENT;
    assign pop = out_valid & out_ready;
    // A full FIFO still accepts a push when the head leaves at the same edge.
    assign can_push = count != FULL || pop;

    rr_arbiter #(.N(NUM_SRC)) u_arb (
        .req         (can_push ? pending : {NUM_SRC{1'b0}}),
        .ptr         (rr_ptr),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    // A drop is an overwrite of a pending event that is not leaving this cycle.
    always_comb begin
        load = '0;
        gnt = '0;
        drop = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            load[i] = src_valid[i] && src_event[i] != NOEVENT;
            gnt[i] = grant_valid && grant_idx == PW'(i);
            drop[i] = load[i] & pending[i] & ~gnt[i];
        end
        drop_sum = {1'b0, drop_cnt} + 9'($countones(drop));
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pending <= '0;
            rr_ptr <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
            drop_cnt <= '0;
        end else begin
            if (grant_valid) begin
                mem[wr_ptr] <= pend_ev[grant_idx];
                wr_ptr <= wr_ptr + 1'b1;
                rr_ptr <= grant_idx == PW'(NUM_SRC - 1) ? '0 : grant_idx + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(grant_valid) - CW'(pop);
            for (int i = 0; i < NUM_SRC; i++) begin
                if (load[i]) begin
                    pending[i] <= 1'b1;
                    pend_ev[i] <= src_event[i];
                end else if (gnt[i]) begin
                    pending[i] <= 1'b0;
                end
            end
            drop_cnt <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
        end
    end
endmodule

// File: tb/tb_event_queue.sv
// tb_event_queue: directed and randomized checks of event_queue against a queue-based model
module tb_event_queue;
    import enum_type::*;
    localparam int DEPTH = 4;
    localparam int NUM_SRC = 5;
    localparam int CW = $clog2(DEPTH) + 1;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic               out_ready = 1'b0;
    logic [NUM_SRC-1:0] src_valid = '0;
    control_type        src_event [NUM_SRC];
    control_type        out_event;
    logic               out_valid;
    logic [CW-1:0]      count;
    logic [7:0]         drop_cnt;

    always #5 clk = ~clk;

    event_queue #(.DEPTH(DEPTH), .NUM_SRC(NUM_SRC)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .src_valid (src_valid),
        .src_event (src_event),
        .out_event (out_event),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count),
        .drop_cnt  (drop_cnt)
    );

    int n_chk = 0;
    int n_pass = 0;

    function automatic void chk(string name, int act, int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endfunction

    // Model: FIFO as a queue, one pending slot per source, pointer search with modulo.
    control_type mq[$];
    control_type m_ev [NUM_SRC];
    bit          m_pend [NUM_SRC];
    int          m_rr = 0;
    int          m_drop = 0;
    bit          m_live = 0;
    bit          m_pop;
    int          m_g;

    always @(posedge clk) begin
        if (!reset_n) begin
            mq.delete();
            m_pend = '{default: 1'b0};
            m_rr = 0;
            m_drop = 0;
            m_live = 1;
        end else begin
            m_pop = mq.size() > 0 && out_ready;
            m_g = -1;
            if (mq.size() < DEPTH || m_pop)
                for (int k = 0; k < NUM_SRC; k++)
                    if (m_g < 0 && m_pend[(m_rr + k) % NUM_SRC]) m_g = (m_rr + k) % NUM_SRC;
            if (m_pop) void'(mq.pop_front());
            if (m_g >= 0) begin
                mq.push_back(m_ev[m_g]);
                m_pend[m_g] = 1'b0;
                m_rr = (m_g + 1) % NUM_SRC;
            end
            for (int i = 0; i < NUM_SRC; i++)
                if (src_valid[i] && src_event[i] != NOEVENT) begin
                    if (m_pend[i]) m_drop = m_drop < 255 ? m_drop + 1 : 255;
                    m_pend[i] = 1'b1;
                    m_ev[i] = src_event[i];
                end
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("m_out_valid", int'(out_valid), int'(mq.size() != 0));
            chk("m_out_event", int'(out_event), mq.size() != 0 ? int'(mq[0]) : int'(NOEVENT));
            chk("m_count", int'(count), mq.size());
            chk("m_drop_cnt", int'(drop_cnt), m_drop);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear();
        src_valid = '0;
        for (int i = 0; i < NUM_SRC; i++) src_event[i] = NOEVENT;
        out_ready = 1'b0;
    endtask

    task automatic do_reset();
        clear();
        reset_n = 1'b0;
        cyc(1);
        reset_n = 1'b1;
    endtask

    control_type all5 [NUM_SRC];
    control_type seq6 [6];
    control_type pop4 [4];

    initial begin
        all5 = '{LEFT, RIGHT, HOLD, ROTATE, DROP};
        seq6 = '{LEFT, RIGHT, HOLD, ROTATE, DROP, RIGHT};
        pop4 = '{RIGHT, HOLD, ROTATE, RIGHT};
        clear();
        do_reset();
        chk("reset_valid", int'(out_valid), 0);
        chk("reset_event", int'(out_event), int'(NOEVENT));
        chk("reset_count", int'(count), 0);

        // single event latency
        src_valid[2] = 1'b1;
        src_event[2] = ROTATE;
        cyc(1);
        chk("single_latched_not_out", int'(out_valid), 0);
        clear();
        cyc(1);
        chk("single_valid", int'(out_valid), 1);
        chk("single_event", int'(out_event), int'(ROTATE));
        out_ready = 1'b1;
        cyc(1);
        chk("single_popped", int'(out_valid), 0);
        out_ready = 1'b0;

        // all sources at once, round-robin order, full push/pop
        do_reset();
        src_valid = '1;
        for (int i = 0; i < NUM_SRC; i++) src_event[i] = all5[i];
        cyc(1);
        clear();
        cyc(5);
        chk("simul_count", int'(count), DEPTH);
        chk("simul_head", int'(out_event), int'(LEFT));
        chk("simul_drop", int'(drop_cnt), 0);
        out_ready = 1'b1;
        for (int k = 0; k < NUM_SRC; k++) begin
            chk("simul_order", int'(out_event), int'(all5[k]));
            cyc(1);
            if (k == 0) chk("full_pushpop_count", int'(count), DEPTH);
        end
        out_ready = 1'b0;
        chk("simul_drained", int'(count), 0);

        // fill and backpressure on one source
        do_reset();
        for (int e = 0; e < 6; e++) begin
            src_valid[0] = 1'b1;
            src_event[0] = seq6[e];
            cyc(1);
            clear();
            cyc(2);
        end
        chk("bp_count", int'(count), DEPTH);
        chk("bp_drop", int'(drop_cnt), 1);
        chk("bp_head", int'(out_event), int'(LEFT));
        out_ready = 1'b1;
        cyc(1);
        out_ready = 1'b0;
        chk("bp_refill_count", int'(count), DEPTH);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("bp_order", int'(out_event), int'(pop4[k]));
            cyc(1);
        end
        out_ready = 1'b0;
        chk("bp_drained", int'(count), 0);

        // drop counter saturation
        do_reset();
        for (int i = 0; i < 4; i++) begin
            src_valid[i] = 1'b1;
            src_event[i] = LEFT;
        end
        cyc(1);
        clear();
        cyc(5);
        src_valid[4] = 1'b1;
        src_event[4] = HOLD;
        cyc(300);
        clear();
        chk("sat_drop", int'(drop_cnt), 255);
        out_ready = 1'b1;
        cyc(10);
        out_ready = 1'b0;
        chk("sat_hold", int'(drop_cnt), 255);

        // reset mid-operation
        do_reset();
        src_valid = '1;
        for (int i = 0; i < NUM_SRC; i++) src_event[i] = all5[i];
        cyc(1);
        clear();
        cyc(3);
        chk("mid_count", int'(count), 3);
        reset_n = 1'b0;
        cyc(1);
        chk("mid_rst_count", int'(count), 0);
        chk("mid_rst_event", int'(out_event), int'(NOEVENT));
        chk("mid_rst_drop", int'(drop_cnt), 0);
        reset_n = 1'b1;
        cyc(6);
        chk("mid_after_valid", int'(out_valid), 0);
        chk("mid_after_count", int'(count), 0);

        // randomized traffic with stall phases and occasional reset
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                src_valid[i] = $urandom_range(0, 3) == 0;
                src_event[i] = control_type'(3'($urandom_range(0, 5)));
            end
            out_ready = ((c / 200) % 2 == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            reset_n = $urandom_range(0, 599) != 0;
            cyc(1);
        end
        clear();
        reset_n = 1'b1;
        cyc(2);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/event_queue.md
EVENT_QUEUE -- requirements
Module: event_queue

Interface
REQ-001 Parameter DEPTH, default 16, FIFO entries; power of two, >= 2.
REQ-002 Parameter NUM_SRC, default 5, number of event sources (UART decoder plus 4 buttons); >= 2.
REQ-003 Port clk  input  1  clock; all logic on rising edge.
REQ-004 Port reset_n  input  1  reset, synchronous, active-low.
REQ-005 Port src_valid  input  NUM_SRC  per-source one-cycle event strobe.
REQ-006 Port src_event  input  NUM_SRC x control_type  per-source event code, sampled when src_valid[i]=1.
REQ-007 Port out_event  output  control_type  FIFO head; NOEVENT when empty.
REQ-008 Port out_valid  output  1  FIFO non-empty.
REQ-009 Port out_ready  input  1  consumer accepts head this cycle.
REQ-010 Port count  output  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH.
REQ-011 Port drop_cnt  output  8  saturating count of lost events.

Function
REQ-012 Each source SHALL have a one-entry pending latch; src_valid[i]=1 with src_event[i]!=NOEVENT loads it at the next edge.
REQ-013 src_valid[i]=1 with src_event[i]=NOEVENT SHALL be ignored, with no drop counted.
REQ-014 A load into an already-pending latch not granted this cycle SHALL overwrite it (last wins) and increment drop_cnt.
REQ-015 A load into the latch granted this same cycle SHALL leave it pending with the new event, with no drop counted.
REQ-016 Multiple sources valid in one cycle SHALL all be latched; none is lost.
REQ-017 Round-robin arbiter: at most one grant per cycle, to the first pending source at index >= rr_ptr, wrapping modulo NUM_SRC.
REQ-018 After a grant, rr_ptr SHALL become (grant+1) mod NUM_SRC; with no grant it SHALL hold.
REQ-019 A grant SHALL occur only when count<DEPTH, or count=DEPTH with a pop in the same cycle.
REQ-020 A granted event SHALL be written at the FIFO tail and its latch cleared at the same edge.
REQ-021 Latency: src_valid at edge t -> latched at t+1 -> written at t+2 (if granted) -> out_valid=1 after t+2.
REQ-022 Pop SHALL occur when out_valid & out_ready; head advances at that edge.
REQ-023 out_ready while empty SHALL have no effect.
REQ-024 Simultaneous push and pop SHALL keep count unchanged, including at count=DEPTH and count=1.
REQ-025 A full FIFO SHALL backpressure into the pending latches: no FIFO overwrite, and drops occur only per REQ-014.
REQ-026 Read/write pointers SHALL be $clog2(DEPTH) bits and wrap naturally; count is tracked separately.
REQ-027 drop_cnt SHALL saturate at 255 and never wrap.
REQ-028 out_event and out_valid SHALL be driven from registered state only, with no combinational path from src_* or out_ready.

Reset
REQ-029 While reset_n=0 at an edge: all latches cleared, rr_ptr=0, pointers=0, count=0, drop_cnt=0.
REQ-030 During and after reset: out_valid=0 and out_event=NOEVENT.
REQ-031 Reset asserted mid-operation SHALL discard all queued and pending events, with no drop counted.

Structure
REQ-032 control_type (including NOEVENT) SHALL remain in shared package enum_type; event_queue imports it.
REQ-033 The round-robin arbiter SHALL be a separate sub-module rr_arbiter with parameter N and ports req, ptr, grant_valid, grant_idx.
REQ-034 FIFO storage SHALL be a register array; no vendor memory primitive.

Verification
REQ-035 Single event: src 2 ROTATE at cycle 0 -> out_valid=1 with out_event=ROTATE at cycle 2; out_ready at cycle 2 -> out_valid=0 at cycle 3.
REQ-036 Simultaneous events: all 5 sources valid at cycle 0 (LEFT,RIGHT,HOLD,ROTATE,DROP), out_ready=0 -> FIFO order LEFT,RIGHT,HOLD,ROTATE,DROP, count=5, drop_cnt=0.
REQ-037 Fill and backpressure: DEPTH=4, 6 events on src 0 spaced 3 cycles, no pop -> count=4, latch holds event 6, drop_cnt=1 (event 5 overwritten); one pop -> event 6 enters, count=4.
REQ-038 Full push/pop: count=DEPTH with a pending event and out_ready=1 -> count stays DEPTH and the pending event is written.
REQ-039 Saturation: 300 overwrites on one blocked source -> drop_cnt=255.
REQ-040 Reset mid-operation: count=3 with 2 pending, reset_n=0 for one cycle -> count=0, out_event=NOEVENT, drop_cnt=0, no events emerge afterwards.
